key_scan_matrix: RTL and testbench
==================================

# key_scan_matrix

Parametrised matrix-keypad scanner with per-key debounce and press/release event reporting. It drives one-hot column strobes, samples row sense lines at the end of each column dwell, and debounces every key independently. It presents both a debounced key bitmap and a single-cycle event (code + valid). It sits between the board keypad pins and the control logic, and replaces the fixed 4x4, undebounced scanner.

## Interface
- `ROWS`, default 4: number of row sense inputs.
- `COLS`, default 4: number of column strobe outputs.
- `DWELL`, default 25: clocks each column is strobed; must be ≥ 2.
- `DEB`, default 4: consecutive identical samples (one per frame) required to change a key's state; must be ≥ 1.
- `CODE_W`, default 4: key code width; must satisfy 2^CODE_W ≥ ROWS*COLS.

Ports:
- `CP` in 1: clock; all logic on rising edge.
- `CR` in 1: synchronous, active-high reset.
- `key_r` in ROWS: row sense, 1 = pressed; externally synchronised.
- `key_o` out COLS: one-hot column strobe.
- `key` out ROWS*COLS: debounced key state, bit index = col*ROWS + row.
- `key_any` out 1: OR of `key`.
- `key_code` out CODE_W: index of the last reported key; holds between events.
- `key_vld` out 1: one-cycle event strobe.
- `key_rel` out 1: event type, 1 = release, 0 = press; valid with `key_vld`.

## Operation
- Dwell counter `cnt` runs 0..DWELL-1. Column index `col` runs 0..COLS-1.
- When `cnt` = DWELL-1, `cnt` wraps to 0 and `col` advances. `col` wraps from COLS-1 to 0.
- `key_o` = one-hot(`col`), decoded combinationally from the `col` register.
- Sample point is the cycle with `cnt` = DWELL-1. At the sample point, raw(col*ROWS+r) = `key_r[r]` for every row r.
- Per-key debounce counter, width sufficient for DEB:
  - raw == `key[i]`: counter cleared.
  - raw != `key[i]` and counter < DEB-1: counter increments.
  - raw != `key[i]` and counter = DEB-1: key i becomes a commit candidate.
- At most one commit per sample point: the candidate with the lowest row index wins.
- Winning candidate: `key[i]` toggles, its counter clears, `key_code` ← i, `key_rel` ← new state inverted, `key_vld` = 1.
- Losing candidates keep their counter at DEB-1 and commit at the next frame's sample of that column, provided they still differ.
- A press event is reported only on a 0→1 transition. A held key produces no further events.
- Release events depend on `KEY_SCAN_RELEASE_EN` (see Configuration).
- Reset values: `cnt`=0, `col`=0 (so `key_o`=1), `key`=0, all debounce counters 0, `key_code`=0, `key_rel`=0, `key_vld`=0, `key_any`=0.
- Reset asserted mid-scan or mid-debounce discards all progress. Every key then needs a full DEB samples again.

## Timing
- Frame length = COLS*DWELL clocks; each key is sampled once per frame.
- Registered outputs update on the clock edge that ends the sample cycle:
  - `key`, `key_code`, `key_rel`, `key_vld`.
  - `key_vld` deasserts on the next edge.
- `key_any` is combinational from `key`.
- Latency, key stable before a sample point → `key_vld`: exactly (DEB-1) frames after that first sample, plus 1 clock.
  - Deferred candidates add one frame per lost arbitration.
- First strobe after reset release: column 0 for DWELL clocks, then column 1.

## Configuration
- `KEY_SCAN_RELEASE_EN` defined:
  - 1→0 commits raise `key_vld` with `key_rel`=1 and `key_code`=i.
  - Release commits arbitrate with press commits under the same lowest-row rule.
- Not defined:
  - 1→0 commits update `key` silently.
  - `key_vld` never fires for releases.
  - `key_rel` is tied to 0.
  - Release commits still participate in the one-commit-per-sample arbitration.

## Test plan
Defaults: ROWS=COLS=4, DWELL=25, DEB=4, frame = 100 clocks.
1. Reset: hold `CR`=1 for 3 clocks, then release → `key`=0, `key_vld`=0, `key_code`=0, `key_o`=4'b0001 for 25 clocks, then 4'b0010.
2. Single press: drive `key_r[2]`=1 whenever `key_o[1]`=1 → at the 4th sample, `key[6]`=1 and one `key_vld` pulse with `key_code`=6, `key_rel`=0. No further pulses while held.
3. Bounce: press key 6 for 3 frames, open 1 frame, press 4 frames → no event during the first burst; exactly one event at the 4th sample of the second burst.
4. Simultaneous: rows 0 and 3 pressed in column 2 → `key_code`=8 at frame N sample, `key_code`=11 one frame later; `key`[8] and `key`[11] both end at 1.
5. Release, key 6 held then opened for 4 frames:
   - Macro defined → `key_vld` with `key_rel`=1, `key_code`=6.
   - Macro undefined → `key[6]`→0 and no pulse.
6. Reset mid-debounce: after 3 matching samples of key 6, pulse `CR` for 1 clock → event occurs only after 4 further frames.

Source files
------------

// File: rtl/key_scan_matrix.sv
// key_scan_matrix: parametrised matrix-keypad scanner.
// Drives one-hot column strobes, samples the row sense lines at the last
// cycle of each column dwell, debounces every key on its own and reports
// press (and optionally release) events as a single-cycle strobe.
// Optional feature macro: KEY_SCAN_RELEASE_EN (report 1->0 commits as events).

module key_scan_matrix #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DWELL  = 25,
  parameter int DEB    = 4,
  parameter int CODE_W = 4
) (
  input  logic                   CP,
  input  logic                   CR,
  input  logic [ROWS-1:0]        key_r,
  output logic [COLS-1:0]        key_o,
  output logic [ROWS*COLS-1:0]   key,
  output logic                   key_any,
  output logic [CODE_W-1:0]      key_code,
  output logic                   key_vld,
  output logic                   key_rel
);

  localparam int NKEYS = ROWS * COLS;
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DEB_W = (DEB > 1) ? $clog2(DEB) : 1;
  localparam int IDX_W = (NKEYS > 1) ? $clog2(NKEYS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB - 1);

  // Scan timing state
  logic [CNT_W-1:0] cnt_r;
  logic [COL_W-1:0] col_r;
  logic             sample_s;

  // Per-key debounce state and per-sample classification
  logic [DEB_W-1:0] deb_r [NKEYS];
  logic [NKEYS-1:0] scan_s;
  logic [NKEYS-1:0] diff_s;
  logic [NKEYS-1:0] cand_s;

  // Arbitration result for the current sample point
  logic             win_any_s;
  logic [IDX_W-1:0] win_idx_s;
  logic             win_new_s;
  logic             report_s;

  // The sample point is the final cycle of each column's dwell.
  assign sample_s = (cnt_r == CNT_LAST);

  // Dwell counter and column index; the column advances as the dwell wraps.
  always_ff @(posedge CP) begin
    if (CR) begin
      cnt_r <= '0;
      col_r <= '0;
    end else if (sample_s) begin
      cnt_r <= '0;
      col_r <= (col_r == COL_LAST) ? '0 : col_r + COL_W'(1);
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
      col_r <= col_r;
    end
  end

  // One-hot column strobe decoded straight from the column register.
  always_comb begin
    key_o = '0;
    for (int c = 0; c < COLS; c++) begin
      key_o[c] = (col_r == COL_W'(c));
    end
  end

  // Classify each key at the sample point: sampled now, differs, ready to commit.
  always_comb begin
    scan_s = '0;
    diff_s = '0;
    cand_s = '0;
    for (int i = 0; i < NKEYS; i++) begin
      scan_s[i] = sample_s && (col_r == COL_W'(i / ROWS));
      diff_s[i] = scan_s[i] && (key_r[i % ROWS] != key[i]);
      cand_s[i] = diff_s[i] && (deb_r[i] == DEB_LAST);
    end
  end

  // Lowest-index candidate wins; all candidates share a column, so this is lowest row.
  always_comb begin
    win_any_s = 1'b0;
    win_idx_s = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      win_any_s = win_any_s | cand_s[i];
      win_idx_s = cand_s[i] ? IDX_W'(i) : win_idx_s;
    end
    win_new_s = ~key[win_idx_s];
  end

  // Decide whether the winning commit is visible as an event.
`ifdef KEY_SCAN_RELEASE_EN
  assign report_s = win_any_s;
`else
  assign report_s = win_any_s & win_new_s;
`endif

  // Per-key debounce counters; a loser stays saturated and retries next frame.
  always_ff @(posedge CP) begin
    for (int i = 0; i < NKEYS; i++) begin
      if (CR) begin
        deb_r[i] <= '0;
      end else if (win_any_s && (win_idx_s == IDX_W'(i))) begin
        deb_r[i] <= '0;
      end else if (!scan_s[i]) begin
        deb_r[i] <= deb_r[i];
      end else if (!diff_s[i]) begin
        deb_r[i] <= '0;
      end else if (deb_r[i] != DEB_LAST) begin
        deb_r[i] <= deb_r[i] + DEB_W'(1);
      end else begin
        deb_r[i] <= deb_r[i];
      end
    end
  end

  // Debounced bitmap and event outputs, all updated on the edge ending the sample cycle.
  always_ff @(posedge CP) begin
    if (CR) begin
      key      <= '0;
      key_code <= '0;
      key_vld  <= 1'b0;
      key_rel  <= 1'b0;
    end else begin
      key_vld <= report_s;
      if (win_any_s) begin
        key[win_idx_s] <= win_new_s;
      end else begin
        key <= key;
      end
      if (report_s) begin
        key_code <= CODE_W'(win_idx_s);
      end else begin
        key_code <= key_code;
      end
`ifdef KEY_SCAN_RELEASE_EN
      if (report_s) begin
        key_rel <= ~win_new_s;
      end else begin
        key_rel <= key_rel;
      end
`else
      key_rel <= 1'b0;
`endif
    end
  end

  // Any key currently held (debounced).
  assign key_any = |key;

  key_scan_matrix_chk #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .CODE_W (CODE_W)
  ) u_chk (
    .CP       (CP),
    .CR       (CR),
    .key_o    (key_o),
    .key_code (key_code),
    .key_vld  (key_vld),
    .key_rel  (key_rel)
  );

endmodule

// key_scan_matrix_chk: structural properties of the scanner outputs.
module key_scan_matrix_chk #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int CODE_W = 4
) (
  input logic              CP,
  input logic              CR,
  input logic [COLS-1:0]   key_o,
  input logic [CODE_W-1:0] key_code,
  input logic              key_vld,
  input logic              key_rel
);

  localparam logic [CODE_W-1:0] CODE_MAX = CODE_W'(ROWS * COLS - 1);

  // Exactly one column is strobed at any time.
  a_strobe_onehot: assert property (@(posedge CP) disable iff (CR) $onehot(key_o));

  // Sample points are at least two clocks apart, so events never run together.
  a_vld_single: assert property (@(posedge CP) disable iff (CR) key_vld |=> !key_vld);

  // A reported code always names a real key.
  a_code_range: assert property (@(posedge CP) disable iff (CR) key_vld |-> (key_code <= CODE_MAX));

`ifndef KEY_SCAN_RELEASE_EN
  // Without release reporting the event type is always press.
  a_rel_tied: assert property (@(posedge CP) disable iff (CR) !key_rel);
`endif

endmodule

// File: tb/tb_key_scan_matrix.sv
// Testbench for key_scan_matrix: directed scenarios plus randomized keypad
// activity, checked against a frame-level behavioural model.

module tb_key_scan_matrix;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int DWELL  = 25;
  localparam int DEB    = 4;
  localparam int CODE_W = 4;
  localparam int NK     = ROWS * COLS;
  localparam int FRAME  = COLS * DWELL;
`ifdef KEY_SCAN_RELEASE_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  logic              CP = 1'b0;
  logic              CR = 1'b1;
  logic [ROWS-1:0]   key_r;
  logic [COLS-1:0]   key_o;
  logic [NK-1:0]     key;
  logic              key_any;
  logic [CODE_W-1:0] key_code;
  logic              key_vld;
  logic              key_rel;

  logic [NK-1:0]     pressed = '0;

  // Reference model state
  logic [NK-1:0]     m_key;
  int                run [NK];
  logic [CODE_W-1:0] m_code;
  logic              m_rel;
  logic              m_vld;
  int                t;
  bit                was_smp;
  bit                prev_smp;
  logic [COLS-1:0]   o_seen;
  logic [COLS-1:0]   o_exp;
  int                pulse_t[$];
  int                pulse_code[$];
  int                pulse_rel[$];

  int checks = 0;
  int errors = 0;

  key_scan_matrix #(
    .ROWS(ROWS), .COLS(COLS), .DWELL(DWELL), .DEB(DEB), .CODE_W(CODE_W)
  ) dut (
    .CP(CP), .CR(CR), .key_r(key_r), .key_o(key_o), .key(key),
    .key_any(key_any), .key_code(key_code), .key_vld(key_vld), .key_rel(key_rel)
  );

  always #5 CP = ~CP;

  // Physical keypad: a row reads 1 when a pressed key sits on the strobed column.
  always_comb begin
    key_r = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (key_o[c] && pressed[c*ROWS + r]) key_r[r] = 1'b1;
      end
    end
  end

  task automatic model_reset();
    m_key  = '0;
    foreach (run[i]) run[i] = 0;
    m_code = '0;
    m_rel  = 1'b0;
    m_vld  = 1'b0;
    t      = 0;
  endtask

  // One column sample: run[] counts consecutive samples that disagree with the
  // debounced state; the lowest row with a run of DEB or more commits.
  task automatic model_sample(input int c);
    int win;
    win = -1;
    for (int r = 0; r < ROWS; r++) begin
      int k;
      k = c*ROWS + r;
      if (pressed[k] == m_key[k]) run[k] = 0;
      else run[k] = run[k] + 1;
      if (win < 0 && run[k] >= DEB) win = k;
    end
    if (win >= 0) begin
      m_key[win] = ~m_key[win];
      run[win] = 0;
      if (m_key[win] || REL_EN) begin
        m_vld  = 1'b1;
        m_code = CODE_W'(win);
        m_rel  = ~m_key[win];
      end
    end
  endtask

  task automatic run_cycle();
    int c;
    bit smp;
    c   = (t / DWELL) % COLS;
    smp = ((t % DWELL) == DWELL - 1);
    o_exp    = '0;
    o_exp[c] = 1'b1;
    o_seen   = key_o;
    m_vld    = 1'b0;
    if (smp) model_sample(c);
    @(posedge CP);
    #1;
    if (key_vld === 1'b1) begin
      pulse_t.push_back(t);
      pulse_code.push_back(int'(key_code));
      pulse_rel.push_back(int'(key_rel));
    end
    prev_smp = was_smp;
    was_smp  = smp;
    t = t + 1;
  endtask

  task automatic do_reset(input int n);
    CR = 1'b1;
    repeat (n) @(posedge CP);
    #1;
    CR = 1'b0;
    model_reset();
    was_smp  = 1'b0;
    prev_smp = 1'b0;
    pulse_t.delete();
    pulse_code.delete();
    pulse_rel.delete();
  endtask

  function automatic int first_of(input int q[$], input int idx);
    if (q.size() > idx) return q[idx];
    return -1;
  endfunction

  task automatic test_reset();
    pressed = '0;
    do_reset(3);
    checks++;
    if (key !== 16'h0000) begin errors++; $display("FAIL reset_key got=%h exp=0000", key); end
    checks++;
    if (key_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", key_vld); end
    checks++;
    if (key_code !== 4'd0) begin errors++; $display("FAIL reset_code got=%0d exp=0", key_code); end
    checks++;
    if (key_any !== 1'b0 || key_rel !== 1'b0) begin
      errors++; $display("FAIL reset_any_rel got=%b%b exp=00", key_any, key_rel);
    end
    for (int i = 0; i < DWELL; i++) begin
      checks++;
      if (key_o !== 4'b0001) begin errors++; $display("FAIL reset_col0 cyc=%0d got=%b exp=0001", i, key_o); end
      run_cycle();
    end
    checks++;
    if (key_o !== 4'b0010) begin errors++; $display("FAIL reset_col1 got=%b exp=0010", key_o); end
  endtask

  task automatic test_single_press();
    do_reset(1);
    pressed = '0;
    pressed[6] = 1'b1;
    repeat (6*FRAME) run_cycle();
    checks++;
    if (pulse_t.size() !== 1) begin errors++; $display("FAIL press_count got=%0d exp=1", pulse_t.size()); end
    checks++;
    if (first_of(pulse_t, 0) !== 3*FRAME + 2*DWELL - 1) begin
      errors++; $display("FAIL press_latency got=%0d exp=%0d", first_of(pulse_t, 0), 3*FRAME + 2*DWELL - 1);
    end
    checks++;
    if (first_of(pulse_code, 0) !== 6 || first_of(pulse_rel, 0) !== 0) begin
      errors++; $display("FAIL press_code got=%0d/%0d exp=6/0", first_of(pulse_code, 0), first_of(pulse_rel, 0));
    end
    checks++;
    if (key !== 16'h0040 || key_any !== 1'b1) begin
      errors++; $display("FAIL press_key got=%h/%b exp=0040/1", key, key_any);
    end
  endtask

  task automatic test_bounce();
    do_reset(1);
    pressed = '0;
    pressed[6] = 1'b1;
    repeat (3*FRAME) run_cycle();
    pressed[6] = 1'b0;
    repeat (FRAME) run_cycle();
    checks++;
    if (pulse_t.size() !== 0 || key !== 16'h0000) begin
      errors++; $display("FAIL bounce_early got=%0d/%h exp=0/0000", pulse_t.size(), key);
    end
    pressed[6] = 1'b1;
    repeat (5*FRAME) run_cycle();
    checks++;
    if (pulse_t.size() !== 1 || first_of(pulse_t, 0) !== 7*FRAME + 2*DWELL - 1 || first_of(pulse_code, 0) !== 6) begin
      errors++;
      $display("FAIL bounce_event got=n%0d t%0d c%0d exp=n1 t%0d c6",
               pulse_t.size(), first_of(pulse_t, 0), first_of(pulse_code, 0), 7*FRAME + 2*DWELL - 1);
    end
  endtask

  task automatic test_simultaneous();
    do_reset(1);
    pressed = '0;
    pressed[8]  = 1'b1;
    pressed[11] = 1'b1;
    repeat (6*FRAME) run_cycle();
    checks++;
    if (pulse_t.size() !== 2) begin errors++; $display("FAIL simul_count got=%0d exp=2", pulse_t.size()); end
    checks++;
    if (first_of(pulse_t, 0) !== 3*FRAME + 3*DWELL - 1 || first_of(pulse_code, 0) !== 8) begin
      errors++; $display("FAIL simul_first got=t%0d c%0d exp=t%0d c8",
                         first_of(pulse_t, 0), first_of(pulse_code, 0), 3*FRAME + 3*DWELL - 1);
    end
    checks++;
    if (first_of(pulse_t, 1) !== 4*FRAME + 3*DWELL - 1 || first_of(pulse_code, 1) !== 11) begin
      errors++; $display("FAIL simul_second got=t%0d c%0d exp=t%0d c11",
                         first_of(pulse_t, 1), first_of(pulse_code, 1), 4*FRAME + 3*DWELL - 1);
    end
    checks++;
    if (key !== 16'h0900) begin errors++; $display("FAIL simul_key got=%h exp=0900", key); end
  endtask

  task automatic test_release();
    do_reset(1);
    pressed = '0;
    pressed[6] = 1'b1;
    repeat (5*FRAME) run_cycle();
    pulse_t.delete();
    pulse_code.delete();
    pulse_rel.delete();
    pressed[6] = 1'b0;
    repeat (5*FRAME) run_cycle();
    checks++;
    if (key !== 16'h0000) begin errors++; $display("FAIL release_key got=%h exp=0000", key); end
`ifdef KEY_SCAN_RELEASE_EN
    checks++;
    if (pulse_t.size() !== 1 || first_of(pulse_t, 0) !== 8*FRAME + 2*DWELL - 1 ||
        first_of(pulse_code, 0) !== 6 || first_of(pulse_rel, 0) !== 1) begin
      errors++;
      $display("FAIL release_event got=n%0d t%0d c%0d r%0d exp=n1 t%0d c6 r1", pulse_t.size(),
               first_of(pulse_t, 0), first_of(pulse_code, 0), first_of(pulse_rel, 0), 8*FRAME + 2*DWELL - 1);
    end
`else
    checks++;
    if (pulse_t.size() !== 0) begin errors++; $display("FAIL release_silent got=%0d exp=0", pulse_t.size()); end
    checks++;
    if (key_code !== 4'd6 || key_rel !== 1'b0) begin
      errors++; $display("FAIL release_hold got=%0d/%b exp=6/0", key_code, key_rel);
    end
`endif
  endtask

  task automatic test_reset_mid_debounce();
    do_reset(1);
    pressed = '0;
    pressed[6] = 1'b1;
    repeat (3*FRAME) run_cycle();
    checks++;
    if (pulse_t.size() !== 0 || key !== 16'h0000) begin
      errors++; $display("FAIL middeb_pre got=%0d/%h exp=0/0000", pulse_t.size(), key);
    end
    do_reset(1);
    repeat (5*FRAME) run_cycle();
    checks++;
    if (pulse_t.size() !== 1 || first_of(pulse_t, 0) !== 3*FRAME + 2*DWELL - 1) begin
      errors++; $display("FAIL middeb_event got=n%0d t%0d exp=n1 t%0d",
                         pulse_t.size(), first_of(pulse_t, 0), 3*FRAME + 2*DWELL - 1);
    end
  endtask

  task automatic test_random();
    do_reset(1);
    pressed = NK'($urandom);
    for (int f = 0; f < 50; f++) begin
      if (f == 25) begin
        do_reset(1);
        checks++;
        if (key !== m_key || key_vld !== 1'b0 || key_code !== m_code) begin
          errors++; $display("FAIL rand_reset got=%h/%b/%0d exp=%h/0/%0d", key, key_vld, key_code, m_key, m_code);
        end
      end
      pressed = pressed ^ NK'($urandom & $urandom & $urandom);
      for (int cyc = 0; cyc < FRAME; cyc++) begin
        if ($urandom_range(0, 49) == 0) pressed[$urandom_range(0, NK-1)] ^= 1'b1;
        run_cycle();
        if (was_smp || prev_smp) begin
          checks++;
          if ({key, key_vld, key_code, key_rel, key_any} !== {m_key, m_vld, m_code, m_rel, |m_key}) begin
            errors++;
            $display("FAIL rand_out t=%0d got key=%h vld=%b code=%0d rel=%b any=%b exp key=%h vld=%b code=%0d rel=%b any=%b",
                     t-1, key, key_vld, key_code, key_rel, key_any, m_key, m_vld, m_code, m_rel, |m_key);
          end
        end
        if (was_smp) begin
          checks++;
          if (o_seen !== o_exp) begin
            errors++; $display("FAIL rand_strobe t=%0d got=%b exp=%b", t-1, o_seen, o_exp);
          end
        end
      end
    end
  endtask

  initial begin
    model_reset();
    was_smp  = 1'b0;
    prev_smp = 1'b0;
    test_reset();
    test_single_press();
    test_bounce();
    test_simultaneous();
    test_release();
    test_reset_mid_debounce();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
